// File: rtl/stream_input_buffer.sv
// stream_input_buffer
//   Receives a T-bit word stream over valid/ready and packs N consecutive
//   words into one bank of a two-bank (ping-pong) buffer. The compute side
//   gets random read access to the oldest complete vector while the next
//   vector streams into the other bank.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   reset     in   asynchronous, active-high reset
//   s_data    in   [T-1:0] stream word
//   s_valid   in   stream word present
//   s_ready   out  buffer can accept a word this cycle (from registered state)
//   rd_addr   in   [A-1:0] word index within the current read bank
//   rd_data   out  [T-1:0] registered read data, one cycle after rd_addr
//   rd_valid  out  current read bank holds a complete vector
//   rd_done   in   one-cycle pulse: compute finished with the read bank
module stream_input_buffer #(
  parameter int unsigned T = 16,
  parameter int unsigned N = 64,
  parameter int unsigned A = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [A-1:0] rd_addr,
  output logic [T-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_done
);

  // One extra bit so the range check also works when N is a power of two.
  localparam int unsigned AE = A + 1;

  logic [1:0]   full_q,    full_d;
  logic         wr_bank_q, wr_bank_d;
  logic [A-1:0] wr_cnt_q,  wr_cnt_d;
  logic         rd_bank_q, rd_bank_d;
  logic [T-1:0] rd_data_q, rd_data_d;

  // Storage is not reset; stale contents are never exposed because a bank
  // only becomes readable after all N words have been rewritten.
  logic [T-1:0] mem_q [2][N];

  logic accept_c;
  logic last_c;
  logic release_c;
  logic addr_ok_c;

  // Next-state logic for fill/release bookkeeping and the read register.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_data_d = '0;

    accept_c  = s_valid && !full_q[wr_bank_q];
    last_c    = accept_c && (wr_cnt_q == A'(N - 1));
    release_c = rd_done && full_q[rd_bank_q];
    addr_ok_c = (AE'(rd_addr) < AE'(N));

    if (accept_c) begin
      wr_cnt_d = wr_cnt_q + A'(1);
    end
    if (last_c) begin
      wr_cnt_d          = '0;
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    // A full bank is never the write target, so this never collides with
    // the set above.
    if (release_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (addr_ok_c) begin
      rd_data_d = mem_q[rd_bank_q][rd_addr];
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffer storage write port.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s_data;
    end
  end

  assign s_ready  = !full_q[wr_bank_q];
  assign rd_valid = full_q[rd_bank_q];
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_stream_input_buffer.sv
// Directed bench for stream_input_buffer with N=8, T=16. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_stream_input_buffer;

  localparam int unsigned T = 16;
  localparam int unsigned N = 8;
  localparam int unsigned A = 3;
  localparam int unsigned NV = 40;

  logic         clk;
  logic         reset;
  logic [T-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [A-1:0] rd_addr;
  logic [T-1:0] rd_data;
  logic         rd_valid;
  logic         rd_done;

  int errors;
  int checks;

  stream_input_buffer #(.T(T), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_done  (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rd_done = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Push N words base..base+N-1 back to back; bank must have room.
  task automatic fill(input int base);
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = T'(base + i);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Read address a; returns data one cycle later (ends on a negedge).
  task automatic rd(input int a, output logic [T-1:0] d);
    rd_addr = A'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    logic [T-1:0] d;
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    rd_addr = '0;
    rd_done = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;

    // Stream 0..7 with s_valid held high
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = T'(i);
      check($sformatf("fill_s_ready_%0d", i), 32'(s_ready), 1);
      check($sformatf("fill_rd_valid_pre_%0d", i), 32'(rd_valid), 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("fill_rd_valid_after", 32'(rd_valid), 1);
    rd(5, d);
    check("fill_read5", 32'(d), 5);

    // Both banks full, 17th word held off, release then read bank 1
    do_reset();
    fill(0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = T'(8);
    for (int i = 0; i < int'(N); i++) begin
      s_data = T'(8 + i);
      @(negedge clk);
    end
    s_data = T'(16);
    check("both_full_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    @(negedge clk);
    check("held_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    rd(3, d);
    check("both_full_read3", 32'(d), 3);
    rd_done = 1'b1;
    check("s_ready_not_comb_from_done", 32'(s_ready), 0);
    @(negedge clk);
    rd_done = 1'b0;
    check("s_ready_after_release", 32'(s_ready), 1);
    check("rd_valid_after_release", 32'(rd_valid), 1);
    rd(3, d);
    check("bank1_read3", 32'(d), 11);
    // Word 16 must not have been taken: next vector into bank 0 starts fresh
    fill(20);
    pulse_done();
    rd(0, d);
    check("no_17th_accept", 32'(d), 20);
    rd(7, d);
    check("refill_read7", 32'(d), 27);

    // Reset mid-fill after 5 words, then a full vector
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = T'(90 + i);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("midrst_s_ready", 32'(s_ready), 1);
    check("midrst_rd_valid", 32'(rd_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    fill(100);
    check("midrst_rd_valid_full", 32'(rd_valid), 1);
    for (int k = 0; k < int'(N); k++) begin
      rd(k, d);
      check($sformatf("midrst_read%0d", k), 32'(d), 32'(100 + k));
    end

    // rd_done with rd_valid=0 is ignored
    do_reset();
    @(negedge clk);
    pulse_done();
    check("ign_done_rd_valid", 32'(rd_valid), 0);
    check("ign_done_rd_bank", 32'(dut.rd_bank_q), 0);
    fill(40);
    check("ign_done_rd_bank_after", 32'(dut.rd_bank_q), 0);
    rd(0, d);
    check("ign_done_read0", 32'(d), 40);
    rd(6, d);
    check("ign_done_read6", 32'(d), 46);

    // Last word of bank 1 accepted together with release of bank 0
    do_reset();
    fill(200);
    for (int i = 0; i < int'(N) - 1; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = T'(300 + i);
    end
    @(negedge clk);
    s_data  = T'(307);
    rd_done = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    rd_done = 1'b0;
    check("simul_rd_valid", 32'(rd_valid), 1);
    check("simul_s_ready", 32'(s_ready), 1);
    check("simul_wr_bank", 32'(dut.wr_bank_q), 0);
    check("simul_rd_bank", 32'(dut.rd_bank_q), 1);
    rd(7, d);
    check("simul_read7", 32'(d), 307);
    rd(0, d);
    check("simul_read0", 32'(d), 300);

    // Random valid/done timing over NV ramp vectors
    do_reset();
    fork
      begin : producer
        int w;
        int cyc;
        logic acc;
        w   = 0;
        cyc = 0;
        while (w < int'(NV * N) && cyc < 20000) begin
          @(negedge clk);
          s_valid = 1'($urandom_range(0, 1));
          s_data  = T'(w);
          acc     = s_valid && s_ready;
          @(posedge clk);
          if (acc) w++;
          cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("rnd_all_words_sent", 32'(w), 32'(NV * N));
      end
      begin : consumer
        logic [T-1:0] rdat;
        for (int v = 0; v < int'(NV); v++) begin
          int wait_cyc;
          wait_cyc = 0;
          @(negedge clk);
          while (!rd_valid && wait_cyc < 500) begin
            @(negedge clk);
            wait_cyc++;
          end
          if (!rd_valid) begin
            check("rnd_wait_rd_valid", 32'(rd_valid), 1);
            break;
          end
          for (int k = 0; k < int'(N); k++) begin
            rd(k, rdat);
            check($sformatf("rnd_v%0d_w%0d", v, k), 32'(rdat), 32'(v * int'(N) + k));
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          pulse_done();
        end
      end
    join
    @(negedge clk);
    check("rnd_end_rd_valid", 32'(rd_valid), 0);
    check("rnd_end_s_ready", 32'(s_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_input_buffer.md
Name: stream_input_buffer

Overview:
- Input-side receiver for the network's streaming interface. Accepts the T-bit input stream over a valid/ready handshake and packs consecutive words into N-word vectors in a ping-pong (two-bank) buffer.
- Gives the layer compute datapath random read access to one complete vector while the next vector streams in.
- Sits between the top-level x_data/x_valid/x_ready port and the first layer's MAC array.

Parameters:
- T, 16, data word width in bits
- N, 64, words per vector (bank depth), N >= 2
- A, $clog2(N), read address width (derived; do not override)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- s_data  input  T  stream input word
- s_valid  input  1  stream word present
- s_ready  output  1  buffer can accept a word this cycle
- rd_addr  input  A  word index within the current read bank
- rd_data  output  T  registered read data
- rd_valid  output  1  current read bank holds a complete vector
- rd_done  input  1  one-cycle pulse: compute finished with current read bank

Behaviour:
- State: full[1:0], wr_bank, wr_cnt (0..N-1), rd_bank, rd_data register; memory 2 x N x T.
- Reset (asynchronous, any time, mid-fill included):
  - full=00, wr_bank=0, rd_bank=0, wr_cnt=0, rd_data=0.
  - Outputs during and after reset: s_ready=1, rd_valid=0.
  - Memory contents are not cleared; a partially filled vector is discarded.
- Handshake:
  - s_ready = !full[wr_bank], combinational from registered state only, never from s_valid.
  - A word is accepted on a rising edge with s_valid && s_ready. Nothing is written otherwise.
  - s_data may be X while s_valid=0.
- Fill:
  - Accepted word is written to mem[wr_bank][wr_cnt] and wr_cnt increments.
  - On the accept at wr_cnt==N-1: wr_cnt goes to 0, full[wr_bank] is set, wr_bank toggles.
- Read:
  - rd_valid = full[rd_bank].
  - rd_data <= mem[rd_bank][rd_addr] every cycle, giving 1-cycle latency.
  - rd_data is don't-care when rd_valid=0.
  - rd_addr >= N (N not a power of 2) loads rd_data=0.
- Release:
  - rd_done && rd_valid on a rising edge clears full[rd_bank] and toggles rd_bank.
  - rd_done with rd_valid=0 is ignored.
  - rd_done high for multiple cycles releases one bank per cycle while rd_valid holds.
- Simultaneous events:
  - Final-word accept into bank X together with rd_done on bank Y (X≠Y) in the same cycle: both take effect.
  - The same bank cannot be both filled and released in one cycle: writes target only non-full banks, releases only full ones.
  - The s_ready rise after a release appears the following cycle (registered full), never combinationally from rd_done.
- Throughput:
  - Back-to-back accept at 1 word/cycle while a bank is free.
  - Both banks full → s_ready=0 until rd_done.
- Ordering:
  - Vectors are presented on the read side in exactly arrival order.
  - Word k of a vector is at rd_addr=k.

Test Plan:
- Reset, then stream 0..7 with s_valid held high (N=8, T=16) -> s_ready high all 8 cycles. rd_valid rises the cycle after the 8th accept. rd_addr=5 gives rd_data=5 one cycle later.
- Stream 16 words 0..15, no rd_done -> both banks full, s_ready=0. A 17th word held with s_valid=1 is not accepted. rd_addr=3 reads 3. Pulse rd_done -> rd_addr=3 reads 11, and s_ready=1 the next cycle.
- Random s_valid (50%) and random rd_done timing over 40 vectors of ramp data -> every vector is read back word-for-word in order, with zero mismatches.
- Assert reset mid-fill after 5 of 8 words, then stream 100..107 -> first full vector reads 100..107 at addresses 0..7; no stale words appear.
- Pulse rd_done with rd_valid=0 after reset, then fill one vector -> vector still reads correctly and rd_bank=0 (the pulse had no effect).
- Accept the last word of bank 1 in the same cycle as rd_done on bank 0 -> the next cycle shows rd_valid=1 with rd_bank=1 data, s_ready=1, and wr_bank=0.
